seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the team's 8-bit combinational 16-op ALU. It keeps the same 4-bit opcode map and adds:
- a valid/ready handshake on input and output;
- iterative multi-cycle multiply (shift-add) and divide (restoring), returning the full double-width product and the remainder;
- a status-flag output.

It sits between operand registers and the writeback stage of the lab datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4; shift-amount field is clog2(WIDTH) bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept a new operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  4  opcode
out_valid  output  1  result/flags valid, held until accepted
out_ready  input  1  consumer accepts result
result  output  WIDTH  primary result
result_hi  output  WIDTH  mul: product high half; div: remainder; else 0
flags  output  5  {dz, ovf, cry, neg, zro}

Behaviour:
- Opcodes:
  - 0 add; 1 sub (a-b); 2 mul unsigned; 3 div unsigned.
  - 4 and; 5 or; 6 xor; 7 not a; 8 pass a; 9 pass b.
  - 10 sll a by b; 11 srl; 12 sra.
  - 13 a+4; 14 a-4; 15 popcount(a), zero-extended.
- Shifts: amount = b as unsigned. If b >= WIDTH: sll/srl give 0; sra gives all copies of a[WIDTH-1].
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: mul/div iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Acceptance = in_valid & in_ready at a rising edge; a, b and op are captured on that edge.
- Single-cycle ops (all except 2 and 3, and div with b=0): result, flags, out_valid=1 registered on the accepting edge, giving 1-cycle latency. Next state DONE.
- mul/div (b!=0):
  - The accepting edge loads the iteration registers and count=WIDTH; next state BUSY.
  - One iteration per BUSY edge.
  - The WIDTH-th iteration edge writes result/result_hi/flags and enters DONE.
  - out_valid is visible WIDTH cycles after the acceptance cycle.
- Div by zero: 1-cycle path; result=all ones, result_hi=a, dz=1.
- DONE:
  - out_ready=0: outputs held stable, no acceptance.
  - out_ready=1 and in_valid=1: new op accepted on the same edge (back-to-back, one op per cycle for single-cycle ops).
  - out_ready=1 and in_valid=0: go to IDLE, out_valid=0; result/result_hi/flags retain last values.
- Flags (computed on the WIDTH-bit result):
  - zro = (result==0).
  - neg = result[WIDTH-1].
  - cry: carry-out for add/inc4; borrow (a<b or a<4, unsigned) for sub/dec4; 0 otherwise.
  - ovf: signed overflow for add/sub/inc4/dec4; for mul, result_hi!=0; 0 otherwise.
  - dz = div with b==0; 0 otherwise.
- Arithmetic wraps modulo 2^WIDTH. Only mul/div drive result_hi.
- Reset:
  - Outputs: result=0, result_hi=0, flags=0, out_valid=0, in_ready=0 during the reset cycle, 1 after.
  - Internal: state=IDLE, count=0.
  - Reset mid-BUSY or in DONE aborts the operation; no result is produced.
- in_valid while BUSY is ignored (in_ready=0). a/b/op changes after acceptance have no effect.

Test Plan:
1. WIDTH=8, add a=8'hF0 b=8'h20 -> next cycle out_valid=1, result=8'h10, cry=1, ovf=0, zro=0.
2. mul a=8'd200 b=8'd3 -> out_valid exactly 8 cycles after acceptance, in_ready=0 meanwhile, result=8'h58, result_hi=8'h02, ovf=1.
3. div a=8'd100 b=8'd7 -> result=14, result_hi=2 after 8 cycles; then div a=5 b=0 -> 1 cycle, result=8'hFF, result_hi=5, dz=1.
4. sra a=8'h90 b=9 -> 8'hFF; srl a=8'h90 b=3 -> 8'h12; popcount a=8'hB7 -> 6.
5. Back-to-back xor/and/sub with out_ready=1 -> one result per cycle in order. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
6. Assert rst in the 4th BUSY cycle of mul -> next cycle IDLE, out_valid=0, result=0, flags=0; no stale result emitted afterwards.

Source files
------------

// File: rtl/seq_alu.sv
// Registered 16-op ALU with valid/ready handshakes, a 1-cycle path for simple ops,
// and iterative shift-add multiply / restoring divide taking WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ONES    = '1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_SLL   = 4'd10;
  localparam logic [3:0] OP_SRL   = 4'd11;
  localparam logic [3:0] OP_SRA   = 4'd12;
  localparam logic [3:0] OP_INC4  = 4'd13;
  localparam logic [3:0] OP_DEC4  = 4'd14;
  localparam logic [3:0] OP_POPC  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, opd_reg;
  logic             is_div_reg;
  logic [WIDTH-1:0] result_reg, result_hi_reg;
  logic [4:0]       flags_reg;

  logic accept, b_zero, start_iter;

  assign in_ready   = ~rst & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
  assign out_valid  = (state_reg == DONE);
  assign accept     = in_valid & in_ready;
  assign b_zero     = (b == '0);
  assign start_iter = (op == OP_MUL) | ((op == OP_DIV) & ~b_zero);

  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign flags     = flags_reg;

  // Ripple popcount over a
  logic [CNT_W-1:0] pop_cnt [0:WIDTH];
  assign pop_cnt[0] = '0;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
      assign pop_cnt[gi+1] = pop_cnt[gi] + CNT_W'(a[gi]);
    end
  endgenerate

  logic             shift_big;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sll_res, srl_res, sra_res;

  assign shift_big = (b >= WIDTH_V);
  assign shamt     = b[SHW-1:0];
  assign sll_res   = shift_big ? '0 : (a << shamt);
  assign srl_res   = shift_big ? '0 : (a >> shamt);
  assign sra_res   = shift_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> shamt);

  // Shared adder for add/sub/inc4/dec4; the top bit is carry or borrow
  logic             addsub_sub;
  logic [WIDTH-1:0] addsub_y;
  logic [WIDTH:0]   addsub_ext;

  always_comb begin
    addsub_sub = (op == OP_SUB) | (op == OP_DEC4);
    addsub_y   = ((op == OP_ADD) | (op == OP_SUB)) ? b : FOUR;
    addsub_ext = addsub_sub ? ({1'b0, a} - {1'b0, addsub_y})
                            : ({1'b0, a} + {1'b0, addsub_y});
  end

  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_cry, alu_ovf, alu_dz;
  logic [4:0]       alu_flags;

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_cry = 1'b0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC4, OP_DEC4: begin
        alu_res = addsub_ext[WIDTH-1:0];
        alu_cry = addsub_ext[WIDTH];
        if (addsub_sub)
          alu_ovf = (a[WIDTH-1] ^ addsub_y[WIDTH-1]) & (a[WIDTH-1] ^ alu_res[WIDTH-1]);
        else
          alu_ovf = ~(a[WIDTH-1] ^ addsub_y[WIDTH-1]) & (a[WIDTH-1] ^ alu_res[WIDTH-1]);
      end
      // Only reaches the output registers when b is zero
      OP_DIV: begin
        alu_res = ONES;
        alu_hi  = a;
        alu_dz  = 1'b1;
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOT:   alu_res = ~a;
      OP_PASSA: alu_res = a;
      OP_PASSB: alu_res = b;
      OP_SLL:   alu_res = sll_res;
      OP_SRL:   alu_res = srl_res;
      OP_SRA:   alu_res = sra_res;
      OP_POPC:  alu_res = WIDTH'(pop_cnt[WIDTH]);
      default:  alu_res = '0;
    endcase
    alu_flags = {alu_dz, alu_ovf, alu_cry, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // One iteration step. hi/lo hold {accumulator, multiplier} for mul and
  // {remainder, quotient} for div; opd holds the multiplicand or divisor.
  logic [WIDTH:0]   mul_sum, rem_shift, trial;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [4:0]       iter_flags;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
    rem_shift = {hi_reg, lo_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, opd_reg};
    if (is_div_reg) begin
      step_hi = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
    iter_flags = {1'b0, ~is_div_reg & (step_hi != '0), 1'b0,
                  step_lo[WIDTH-1], (step_lo == '0)};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = start_iter ? BUSY : DONE;
      BUSY: if (count_reg == CNT_W'(1)) state_next = DONE;
      DONE: begin
        if (out_ready) state_next = accept ? (start_iter ? BUSY : DONE) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opd_reg       <= '0;
      is_div_reg    <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
    end else if (accept) begin
      if (start_iter) begin
        hi_reg     <= '0;
        lo_reg     <= a;
        opd_reg    <= b;
        is_div_reg <= (op == OP_DIV);
        count_reg  <= CNT_W'(WIDTH);
      end else begin
        result_reg    <= alu_res;
        result_hi_reg <= alu_hi;
        flags_reg     <= alu_flags;
        count_reg     <= '0;
      end
    end else if (state_reg == BUSY) begin
      hi_reg    <= step_hi;
      lo_reg    <= step_lo;
      count_reg <= count_reg - CNT_W'(1);
      if (count_reg == CNT_W'(1)) begin
        result_reg    <= step_lo;
        result_hi_reg <= step_hi;
        flags_reg     <= iter_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int WIDTH = 8;
  localparam int M     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [4:0]       flags;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [4:0]       flg;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic exp_t model(input int x, input int y, input int code);
    int r, h, s;
    bit dz, ovf, cry;
    exp_t e;
    r = 0; h = 0; s = 0; dz = 0; ovf = 0; cry = 0;
    case (code)
      0: begin
        s = x + y; r = s % M; cry = (s >= M);
        s = to_signed(x) + to_signed(y); ovf = (s >= M / 2) || (s < -M / 2);
      end
      1: begin
        r = (x - y + M) % M; cry = (x < y);
        s = to_signed(x) - to_signed(y); ovf = (s >= M / 2) || (s < -M / 2);
      end
      2: begin s = x * y; r = s % M; h = s / M; ovf = (h != 0); end
      3: begin
        if (y == 0) begin r = M - 1; h = x; dz = 1; end
        else begin r = x / y; h = x % y; end
      end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      7: r = (M - 1) - x;
      8: r = x;
      9: r = y;
      10: r = (y >= WIDTH) ? 0 : (x << y) % M;
      11: r = (y >= WIDTH) ? 0 : (x >> y);
      12: r = (y >= WIDTH) ? ((x >= M / 2) ? M - 1 : 0) : ((to_signed(x) >>> y) & (M - 1));
      13: begin
        s = x + 4; r = s % M; cry = (s >= M);
        s = to_signed(x) + 4; ovf = (s >= M / 2);
      end
      14: begin
        r = (x - 4 + M) % M; cry = (x < 4);
        s = to_signed(x) - 4; ovf = (s < -M / 2);
      end
      default: r = $countones(x);
    endcase
    e.res = WIDTH'(r);
    e.hi  = WIDTH'(h);
    e.flg = {dz, ovf, cry, (r >= M / 2), (r == 0)};
    return e;
  endfunction

  // Full transaction from IDLE: issue, wait for the result, stall, then release.
  task automatic run_op(input int x, input int y, input int code, input int stall,
                        output exp_t seen);
    exp_t e;
    int   n;
    bit   iter;
    bit   busy_ready;
    e    = model(x, y, code);
    iter = (code == 2) || (code == 3 && y != 0);
    n = 0;
    while (!in_ready && n < 4 * WIDTH) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 1);
    a = x[WIDTH-1:0]; b = y[WIDTH-1:0]; op = code[3:0];
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 4'($urandom);
    n = 0; busy_ready = 1'b0;
    while (!out_valid && n < 4 * WIDTH) begin
      busy_ready |= in_ready;
      @(posedge clk); #1; n++;
    end
    check("latency", n, iter ? WIDTH : 0);
    if (iter) check("busy_in_ready", 32'(busy_ready), 0);
    check("out_valid", 32'(out_valid), 1);
    check("result", 32'(result), 32'(e.res));
    check("result_hi", 32'(result_hi), 32'(e.hi));
    check("flags", 32'(flags), 32'(e.flg));
    seen = {result, result_hi, flags};
    $display("op=%0d a=%02h b=%02h -> result=%02h hi=%02h flags=%05b lat=%0d (exp %02h %02h %05b)",
             code, x, y, result, result_hi, flags, n, e.res, e.hi, e.flg);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_result", 32'({result, result_hi, flags}), 32'(e));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("drop_valid", 32'(out_valid), 0);
    check("retain_result", 32'({result, result_hi, flags}), 32'(e));
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t seen, e;
    int   x, y, code;
    int   bx [3];
    int   by [3];
    int   bop [3];
    bit   seen_valid;
    bx  = '{8'hA5, 8'hF0, 8'h10};
    by  = '{8'h3C, 8'h3C, 8'h20};
    bop = '{6, 4, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_result", 32'({result, result_hi, flags}), 0);
    rst = 1'b0; #1;
    check("post_reset_in_ready", 32'(in_ready), 1);

    run_op(8'hF0, 8'h20, 0, 0, seen);
    check("tp1_result", 32'(seen.res), 32'h10);
    check("tp1_cry_ovf", 32'(seen.flg[3:2]), 32'b01);
    run_op(200, 3, 2, 1, seen);
    check("tp2_result", 32'(seen.res), 32'h58);
    check("tp2_hi", 32'(seen.hi), 32'h02);
    check("tp2_ovf", 32'(seen.flg[3]), 1);
    run_op(100, 7, 3, 0, seen);
    check("tp3_quot", 32'(seen.res), 14);
    check("tp3_rem", 32'(seen.hi), 2);
    run_op(5, 0, 3, 2, seen);
    check("tp3_dz", 32'({seen.res, seen.hi, seen.flg[4]}), 32'({8'hFF, 8'h05, 1'b1}));
    run_op(8'h90, 9, 12, 0, seen);
    check("tp4_sra", 32'(seen.res), 32'hFF);
    run_op(8'h90, 3, 11, 0, seen);
    check("tp4_srl", 32'(seen.res), 32'h12);
    run_op(8'hB7, 0, 15, 0, seen);
    check("tp4_popc", 32'(seen.res), 6);
    run_op(8'h81, 8, 10, 0, seen);
    run_op(8'h7C, 0, 13, 0, seen);
    run_op(8'h02, 0, 14, 0, seen);
    run_op(255, 255, 2, 0, seen);
    run_op(255, 1, 3, 0, seen);

    // Back-to-back single-cycle ops, then a stall
    out_ready = 1'b1;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'(bx[i]); b = WIDTH'(by[i]); op = 4'(bop[i]); in_valid = 1'b1;
      check("b2b_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      e = model(bx[i], by[i], bop[i]);
      check("b2b_valid", 32'(out_valid), 1);
      check("b2b_result", 32'(result), 32'(e.res));
      check("b2b_flags", 32'(flags), 32'(e.flg));
      $display("b2b op=%0d a=%02h b=%02h -> result=%02h flags=%05b (exp %02h %05b)",
               bop[i], bx[i], by[i], result, flags, e.res, e.flg);
    end
    out_ready = 1'b0; in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); op = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_result", 32'(result), 32'(e.res));
      check("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", 32'(out_valid), 0);

    // Reset during the 4th BUSY cycle of a multiply
    a = 8'd200; b = 8'd3; op = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_busy_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_result", 32'({result, result_hi, flags}), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    seen_valid = 1'b0;
    repeat (2 * WIDTH) begin
      @(posedge clk); #1;
      seen_valid |= out_valid;
    end
    check("abort_no_stale", 32'(seen_valid), 0);
    out_ready = 1'b0;
    $display("reset abort of mul observed: out_valid stayed %0b", seen_valid);

    for (int i = 0; i < 150; i++) begin
      code = $urandom_range(0, 15);
      x    = $urandom_range(0, M - 1);
      y    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WIDTH + 1) : $urandom_range(0, M - 1);
      run_op(x, y, code, $urandom_range(0, 2), seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
